// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue between the I-cache and decode.
// Optional performance counters are enabled by defining IFQ_PERF_EN.
module instruction_fetch_queue #(
  parameter int ADDR_W = 30,
  parameter int INSN_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_src,
  input  logic [ADDR_W-1:0]          branch_addr,
  input  logic                       data_hit,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_req,
  input  logic                       imem_hit,
  input  logic [INSN_W-1:0]          imem_rdata,
  output logic [INSN_W-1:0]          ins,
  output logic [ADDR_W-1:0]          adder_output,
  output logic                       ins_valid,
  output logic [$clog2(DEPTH):0]     q_count
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_miss_cyc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_MISS, S_FULL} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [INSN_W-1:0]   q_insn [DEPTH];
  logic [ADDR_W-1:0]   q_npc  [DEPTH];

  logic                full, pop, push, redirect;
  logic [ADDR_W-1:0]   fetch_pc_inc;
  logic [PTR_W-1:0]    rd_next;
  logic [CNT_W-1:0]    remaining;
  logic                head_from_push, head_load;

  assign full         = (count == CNT_W'(DEPTH));
  assign ins_valid    = (count != '0);
  assign pop          = ins_valid & data_hit;
  assign redirect     = pc_src & (state != S_BOOT);
  assign push         = imem_req & imem_hit & (!full | pop) & !redirect;
  assign fetch_pc_inc = fetch_pc + 1'b1;
  assign imem_addr    = fetch_pc;
  assign q_count      = count;

  // The head register reloads from the queue slot behind the popped one, or straight
  // from the incoming word when the queue would otherwise drain empty.
  assign rd_next        = rd_ptr + PTR_W'(pop);
  assign remaining      = count - CNT_W'(pop);
  assign head_from_push = push & (remaining == '0);
  assign head_load      = !redirect & (head_from_push | (pop & (remaining != '0)));

  always_ff @(posedge clk) begin
    if (push) begin
      q_insn[wr_ptr] <= imem_rdata;
      q_npc[wr_ptr]  <= fetch_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      ins          <= '0;
      adder_output <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= branch_addr;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) fetch_pc <= fetch_pc_inc;
        count  <= count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr <= rd_next;
        wr_ptr <= wr_ptr + PTR_W'(push);
      end
      if (head_load) begin
        ins          <= head_from_push ? imem_rdata   : q_insn[rd_next];
        adder_output <= head_from_push ? fetch_pc_inc : q_npc[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      imem_req <= 1'b0;
    end else if (redirect) begin
      state    <= S_RUN;
      imem_req <= 1'b1;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_RUN;
          imem_req <= 1'b1;
        end
        S_RUN, S_MISS: begin
          if (!imem_hit) begin
            state    <= S_MISS;
            imem_req <= 1'b1;
          end else if (full && !pop) begin
            state    <= S_FULL;
            imem_req <= 1'b0;
          end else begin
            state    <= S_RUN;
            imem_req <= 1'b1;
          end
        end
        S_FULL: begin
          if (pop) begin
            state    <= S_RUN;
            imem_req <= 1'b1;
          end else begin
            state    <= S_FULL;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // A miss cycle is any lookup cycle the cache fails to answer, whether in S_RUN or S_MISS.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_miss_cyc <= '0;
    end else begin
      perf_fetched  <= sat_inc(perf_fetched, push);
      perf_miss_cyc <= sat_inc(perf_miss_cyc, imem_req & !imem_hit);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: boot, stall/fill, miss, redirect, wrap, reset.
// I-cache model returns address + 0x100 as the instruction word.
module tb_instruction_fetch_queue;

  localparam int ADDR_W = 30;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pc_src;
  logic [ADDR_W-1:0] branch_addr;
  logic              data_hit;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_req;
  logic              imem_hit;
  logic [INSN_W-1:0] imem_rdata;
  logic [INSN_W-1:0] ins;
  logic [ADDR_W-1:0] adder_output;
  logic              ins_valid;
  logic [2:0]        q_count;
`ifdef IFQ_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_miss_cyc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = INSN_W'(imem_addr) + 32'h100;

  instruction_fetch_queue #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .branch_addr(branch_addr), .data_hit(data_hit),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_hit(imem_hit), .imem_rdata(imem_rdata),
    .ins(ins), .adder_output(adder_output), .ins_valid(ins_valid), .q_count(q_count)
`ifdef IFQ_PERF_EN
    , .perf_fetched(perf_fetched), .perf_miss_cyc(perf_miss_cyc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] addr);
    pc_src      = 1'b1;
    branch_addr = addr;
    step();
    pc_src      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_src = 1'b0; branch_addr = '0; data_hit = 1'b1; imem_hit = 1'b1;
    step(); step();
    chk("rst_count", q_count, 0);
    chk("rst_valid", ins_valid, 0);
    chk("rst_ins", ins, 0);
    chk("rst_adder", adder_output, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);

    // boot: one idle lookup cycle, then streaming
    rst = 1'b0;
    chk("boot_req", imem_req, 0);
    step();
    chk("run_req", imem_req, 1);
    chk("run_addr", imem_addr, 0);
    chk("run_valid", ins_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_ins", ins, 32'h100 + k);
      chk("t1_adder", adder_output, k + 1);
      chk("t1_valid", ins_valid, 1);
      chk("t1_count", q_count, 1);
    end

    // stall downstream until full
    data_hit = 1'b0;
    redirect(0);
    chk("t2_flush", q_count, 0);
    chk("t2_addr0", imem_addr, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("t2_count", q_count, (i < 4) ? i : 4);
      chk("t2_addr", imem_addr, (i < 4) ? i : 4);
      chk("t2_req", imem_req, (i <= 4) ? 1 : 0);
    end
    chk("t2_head", ins, 32'h100);
    data_hit = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t2_drain_ins", ins, 32'h100 + j);
      chk("t2_drain_cnt", q_count, 3);
      chk("t2_drain_addr", imem_addr, (j == 1) ? 4 : 3 + j);
    end

    // I-cache miss at address 2
    redirect(0);
    step();
    chk("t3_ins0", ins, 32'h100);
    step();
    chk("t3_ins1", ins, 32'h101);
    chk("t3_addr2", imem_addr, 2);
    imem_hit = 1'b0;
    for (int m = 0; m < 3; m++) begin
      step();
      chk("t3_miss_addr", imem_addr, 2);
      chk("t3_miss_valid", ins_valid, 0);
      chk("t3_miss_req", imem_req, 1);
    end
    chk("t3_hold_ins", ins, 32'h101);
    imem_hit = 1'b1;
    step();
    chk("t3_ins2", ins, 32'h102);
    chk("t3_adder", adder_output, 3);
    chk("t3_valid", ins_valid, 1);
    chk("t3_addr3", imem_addr, 3);
`ifdef IFQ_PERF_EN
    chk("t3_perf_miss", perf_miss_cyc, 3);
    chk("t3_perf_fetch", perf_fetched, 13);
`endif

    // redirect with three entries held
    data_hit = 1'b0;
    step(); step();
    chk("t4_count3", q_count, 3);
    redirect(31);
    chk("t4_valid", ins_valid, 0);
    chk("t4_count", q_count, 0);
    chk("t4_addr", imem_addr, 31);
    data_hit = 1'b1;
    step();
    chk("t4_ins", ins, 32'h11F);
    chk("t4_adder", adder_output, 32);
    chk("t4_valid1", ins_valid, 1);

    // PC wrap at the top of the address space
    redirect(30'h3FFF_FFFF);
    chk("t5_addr", imem_addr, 30'h3FFF_FFFF);
    step();
    chk("t5_ins", ins, 32'h4000_00FF);
    chk("t5_adder", adder_output, 0);
    chk("t5_addr0", imem_addr, 0);

    // reset while full and redirecting
    data_hit = 1'b0;
    redirect(0);
    for (int n = 0; n < 5; n++) step();
    chk("t6_full", q_count, 4);
    chk("t6_full_req", imem_req, 0);
    rst = 1'b1; pc_src = 1'b1; branch_addr = 31;
    step();
    chk("t6_count", q_count, 0);
    chk("t6_valid", ins_valid, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_req", imem_req, 0);
    chk("t6_ins", ins, 0);
    rst = 1'b0; pc_src = 1'b0;
    chk("t6_boot_req", imem_req, 0);
    step();
    chk("t6_run_req", imem_req, 1);
    chk("t6_run_addr", imem_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
